// File: rtl/acc_buffer.sv
// acc_buffer: ping-pong partial-sum accumulator with saturation, draining finished tiles to the PPU
module acc_buffer #(
    parameter int PSUM_W = 20,
    parameter int ACC_W  = 24,
    parameter int LANES  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_psum_valid,
    input  logic [LANES*PSUM_W-1:0] i_psum_data,
    input  logic                    i_psum_first,
    input  logic                    i_psum_last,
    output logic                    o_psum_ready,
    output logic                    o_ppu_start,
    output logic [LANES*ACC_W-1:0]  o_acc_data,
    output logic                    o_sat
);
    localparam int ROW_W = LANES * ACC_W;

    typedef enum logic [1:0] {IDLE, START, STREAM} state_t;

    logic [ROW_W-1:0] mem_q [2][16];
    logic [ROW_W-1:0] mem_d [2][16];
    logic [1:0]       full_q, full_d;
    logic             wr_bank_q, wr_bank_d;
    logic [3:0]       wr_row_q, wr_row_d;
    logic             rd_bank_q, rd_bank_d;
    logic [3:0]       rd_row_q, rd_row_d;
    state_t           state_q, state_d;
    logic             sat_q, sat_d;

    logic             accept, tile_done, drain_done, clamp_any;
    logic [ROW_W-1:0] new_row;
    logic [ACC_W-1:0] old_lane;
    logic [PSUM_W-1:0] psum_lane;
    logic [ACC_W:0]   sum;

    assign accept       = i_psum_valid && o_psum_ready;
    assign tile_done    = accept && wr_row_q == 4'hf && i_psum_last;
    assign o_psum_ready = !full_q[wr_bank_q];
    assign o_sat        = sat_q;

    // Per-lane overwrite or saturating add of the incoming row into the addressed accumulator row
    always_comb begin
        new_row   = '0;
        clamp_any = 1'b0;
        old_lane  = '0;
        psum_lane = '0;
        sum       = '0;
        for (int g = 0; g < LANES; g++) begin
            old_lane  = mem_q[wr_bank_q][wr_row_q][g*ACC_W +: ACC_W];
            psum_lane = i_psum_data[g*PSUM_W +: PSUM_W];
            sum = {old_lane[ACC_W-1], old_lane} + {{(ACC_W+1-PSUM_W){psum_lane[PSUM_W-1]}}, psum_lane};
            if (i_psum_first) begin
                new_row[g*ACC_W +: ACC_W] = {{(ACC_W-PSUM_W){psum_lane[PSUM_W-1]}}, psum_lane};
            end else if (sum[ACC_W] != sum[ACC_W-1]) begin
                new_row[g*ACC_W +: ACC_W] = {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}};
                clamp_any = 1'b1;
            end else begin
                new_row[g*ACC_W +: ACC_W] = sum[ACC_W-1:0];
            end
        end
    end

    // Write-side bookkeeping: storage update, row/bank counters, sticky saturation
    always_comb begin
        mem_d = mem_q;
        if (accept) mem_d[wr_bank_q][wr_row_q] = new_row;
        wr_row_d  = accept ? wr_row_q + 4'd1 : wr_row_q;
        wr_bank_d = wr_bank_q ^ tile_done;
        sat_d     = sat_q | (accept & ~i_psum_first & clamp_any);
    end

    // Drain FSM: announce a full bank with one start pulse, then stream its 16 rows
    always_comb begin
        state_d     = state_q;
        rd_row_d    = rd_row_q;
        rd_bank_d   = rd_bank_q;
        drain_done  = 1'b0;
        o_ppu_start = 1'b0;
        o_acc_data  = '0;
        case (state_q)
            IDLE: if (full_q[rd_bank_q]) state_d = START;
            START: begin
                o_ppu_start = 1'b1;
                rd_row_d    = 4'd0;
                state_d     = STREAM;
            end
            STREAM: begin
                o_acc_data = mem_q[rd_bank_q][rd_row_q];
                rd_row_d   = rd_row_q + 4'd1;
                if (rd_row_q == 4'hf) begin
                    drain_done = 1'b1;
                    rd_bank_d  = !rd_bank_q;
                    state_d    = full_q[!rd_bank_q] ? START : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Full flags: set and clear always hit different banks, so both apply
    always_comb begin
        full_d = full_q;
        if (drain_done) full_d[rd_bank_q] = 1'b0;
        if (tile_done) full_d[wr_bank_q] = 1'b1;
    end

    // Accumulator storage; contents need no reset because cleared full flags discard them
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    // Control state registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            wr_row_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_row_q  <= '0;
            state_q   <= IDLE;
            sat_q     <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_row_q  <= wr_row_d;
            rd_bank_q <= rd_bank_d;
            rd_row_q  <= rd_row_d;
            state_q   <= state_d;
            sat_q     <= sat_d;
        end
    end
endmodule

// File: tb/tb_acc_buffer.sv
// tb_acc_buffer: directed scenario tests for acc_buffer
module tb_acc_buffer;
    localparam int PSUM_W = 20;
    localparam int ACC_W  = 24;
    localparam int LANES  = 16;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    psum_valid = 1'b0;
    logic                    psum_first = 1'b0;
    logic                    psum_last = 1'b0;
    logic [LANES*PSUM_W-1:0] psum_data = '0;
    logic                    psum_ready, ppu_start, sat;
    logic [LANES*ACC_W-1:0]  acc_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int starts = 0;
    int last_acc = 0;
    int stalls = 0;

    acc_buffer #(.PSUM_W(PSUM_W), .ACC_W(ACC_W), .LANES(LANES)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_psum_valid(psum_valid),
        .i_psum_data (psum_data),
        .i_psum_first(psum_first),
        .i_psum_last (psum_last),
        .o_psum_ready(psum_ready),
        .o_ppu_start (ppu_start),
        .o_acc_data  (acc_data),
        .o_sat       (sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ppu_start) starts <= starts + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // mode 0: lane = r*16+g+val ; mode 1: every lane = val
    function automatic logic [LANES*PSUM_W-1:0] mk_psum(input int mode, input int val, input int r);
        logic [LANES*PSUM_W-1:0] v;
        for (int g = 0; g < LANES; g++) v[g*PSUM_W +: PSUM_W] = PSUM_W'(mode == 0 ? r*16 + g + val : val);
        return v;
    endfunction

    function automatic logic [LANES*ACC_W-1:0] exp_row(input int mode, input int val, input int r);
        logic [LANES*ACC_W-1:0] v;
        for (int g = 0; g < LANES; g++) v[g*ACC_W +: ACC_W] = ACC_W'(mode == 0 ? r*16 + g + val : val);
        return v;
    endfunction

    task automatic drive_chunk(input logic f, input logic l, input int mode, input int val);
        int n;
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            psum_valid = 1'b1;
            psum_first = f;
            psum_last  = l;
            psum_data  = mk_psum(mode, val, r);
            n = 0;
            while (!psum_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) begin
                checks++;
                errors++;
                $display("FAIL drive ready timeout: ready=%b after %0d cycles, want 1", psum_ready, n);
            end
            stalls += n;
            last_acc = cyc;
            @(posedge clk);
            #1 psum_valid = 1'b0;
        end
    endtask

    task automatic drain_tile(input string name, input int mode, input int val, output int st);
        int n = 0;
        while (!ppu_start && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ppu_start !== 1'b1) begin
            errors++;
            $display("FAIL %s start: o_ppu_start=%b after %0d cycles, want 1", name, ppu_start, n);
        end
        st = cyc;
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            checks++;
            if (acc_data !== exp_row(mode, val, r) || ppu_start !== 1'b0) begin
                errors++;
                $display("FAIL %s row %0d: got %h start=%b, want %h start=0", name, r, acc_data, ppu_start, exp_row(mode, val, r));
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (psum_ready !== 1'b1) begin errors++; $display("FAIL reset ready: got %b want 1", psum_ready); end
        checks++;
        if (ppu_start !== 1'b0) begin errors++; $display("FAIL reset start: got %b want 0", ppu_start); end
        checks++;
        if (acc_data !== '0) begin errors++; $display("FAIL reset data: got %h want 0", acc_data); end
        checks++;
        if (sat !== 1'b0) begin errors++; $display("FAIL reset sat: got %b want 0", sat); end
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        int t, st;
        drive_chunk(1'b1, 1'b1, 0, 0);
        t = last_acc;
        drain_tile("single", 0, 0, st);
        checks++;
        if (st !== t + 2) begin errors++; $display("FAIL single start cycle: got %0d want %0d", st, t + 2); end
        checks++;
        if (sat !== 1'b0) begin errors++; $display("FAIL single sat: got %b want 0", sat); end
        @(negedge clk);
        checks++;
        if (acc_data !== '0 || ppu_start !== 1'b0) begin
            errors++;
            $display("FAIL single idle after drain: data=%h start=%b, want 0 and 0", acc_data, ppu_start);
        end
    endtask

    task automatic test_accumulate;
        int s0, st;
        s0 = starts;
        drive_chunk(1'b1, 1'b0, 1, 1000);
        drive_chunk(1'b0, 1'b0, 1, -300);
        drive_chunk(1'b0, 1'b1, 1, 1000);
        drain_tile("accum", 1, 1700, st);
        repeat (3) @(negedge clk);
        checks++;
        if (starts - s0 !== 1) begin errors++; $display("FAIL accum start count: got %0d want 1", starts - s0); end
    endtask

    task automatic test_saturation;
        int st;
        drive_chunk(1'b1, 1'b0, 1, 524287);
        for (int i = 0; i < 15; i++) drive_chunk(1'b0, 1'b0, 1, 524287);
        @(negedge clk);
        checks++;
        if (sat !== 1'b0) begin errors++; $display("FAIL sat below limit: got %b want 0", sat); end
        for (int i = 0; i < 4; i++) drive_chunk(1'b0, 1'b0, 1, 524287);
        drive_chunk(1'b0, 1'b1, 1, 524287);
        drain_tile("sat_pos", 1, 8388607, st);
        checks++;
        if (sat !== 1'b1) begin errors++; $display("FAIL sat positive: got %b want 1", sat); end
        drive_chunk(1'b1, 1'b0, 1, -524288);
        for (int i = 0; i < 19; i++) drive_chunk(1'b0, 1'b0, 1, -524288);
        drive_chunk(1'b0, 1'b1, 1, -524288);
        drain_tile("sat_neg", 1, -8388608, st);
        checks++;
        if (sat !== 1'b1) begin errors++; $display("FAIL sat sticky: got %b want 1", sat); end
    endtask

    task automatic test_back_to_back;
        int t1, s1, s2, s3;
        stalls = 0;
        fork
            begin
                drive_chunk(1'b1, 1'b1, 0, 1000);
                t1 = last_acc;
                drive_chunk(1'b1, 1'b1, 0, 2000);
                drive_chunk(1'b1, 1'b1, 0, 3000);
            end
            begin
                drain_tile("pp_t1", 0, 1000, s1);
                drain_tile("pp_t2", 0, 2000, s2);
                drain_tile("pp_t3", 0, 3000, s3);
            end
        join
        checks++;
        if (s1 !== t1 + 2) begin errors++; $display("FAIL pp first start: got %0d want %0d", s1, t1 + 2); end
        checks++;
        if (s2 - s1 !== 17) begin errors++; $display("FAIL pp spacing 1-2: got %0d want 17", s2 - s1); end
        checks++;
        if (s3 - s2 !== 17) begin errors++; $display("FAIL pp spacing 2-3: got %0d want 17", s3 - s2); end
        checks++;
        if (stalls !== 2) begin errors++; $display("FAIL pp ready stall cycles: got %0d want 2", stalls); end
    endtask

    task automatic test_row_wrap;
        int s0, st;
        s0 = starts;
        drive_chunk(1'b1, 1'b0, 1, 5);
        repeat (4) @(negedge clk);
        checks++;
        if (starts !== s0 || psum_ready !== 1'b1) begin
            errors++;
            $display("FAIL wrap no-last: starts=%0d ready=%b, want %0d and 1", starts, psum_ready, s0);
        end
        drive_chunk(1'b0, 1'b1, 1, 7);
        drain_tile("wrap", 1, 12, st);
        repeat (2) @(negedge clk);
        checks++;
        if (starts - s0 !== 1) begin errors++; $display("FAIL wrap start count: got %0d want 1", starts - s0); end
    endtask

    task automatic test_reset_mid_stream;
        int n, s0, t, st;
        drive_chunk(1'b1, 1'b1, 0, 0);
        n = 0;
        while (!ppu_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 8; k++) @(negedge clk);
        checks++;
        if (acc_data !== exp_row(0, 0, 7)) begin errors++; $display("FAIL rst row7 before reset: got %h want %h", acc_data, exp_row(0, 0, 7)); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (acc_data !== '0 || ppu_start !== 1'b0 || psum_ready !== 1'b1 || sat !== 1'b0) begin
            errors++;
            $display("FAIL rst immediate: data=%h start=%b ready=%b sat=%b, want 0 0 1 0", acc_data, ppu_start, psum_ready, sat);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = starts;
        repeat (25) @(negedge clk);
        checks++;
        if (starts !== s0) begin errors++; $display("FAIL rst spurious start: got %0d want %0d", starts, s0); end
        drive_chunk(1'b1, 1'b1, 0, 77);
        t = last_acc;
        drain_tile("post_reset", 0, 77, st);
        checks++;
        if (st !== t + 2) begin errors++; $display("FAIL post_reset start cycle: got %0d want %0d", st, t + 2); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_accumulate();
        test_saturation();
        test_back_to_back();
        test_row_wrap();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/acc_buffer.md
# acc_buffer

Double-buffered partial-sum accumulator between the systolic array and the post-processing unit (PPU). Accumulates 16-row × 16-lane partial-sum tiles over K-chunks with signed saturation. Streams each finished tile to the PPU as one start pulse followed by 16 consecutive row beats. Two ping-pong banks let the next tile accumulate while the previous one drains.

## Interface

Parameters:
- PSUM_W, 20, signed width of one incoming partial-sum lane
- ACC_W, 24, signed width of one accumulator lane; must equal the PPU input lane width
- LANES, 16, lanes per row (fixed at 16)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_psum_valid  in  1  partial-sum row beat valid
- i_psum_data  in  LANES*PSUM_W  one row; lane g at [g*PSUM_W +: PSUM_W]
- i_psum_first  in  1  beat belongs to the first K-chunk: overwrite, do not add
- i_psum_last  in  1  beat belongs to the final K-chunk of the tile
- o_psum_ready  out  1  beat accepted when valid && ready
- o_ppu_start  out  1  one-cycle pulse; row 0 follows on the next cycle
- o_acc_data  out  LANES*ACC_W  streamed row; lane g at [g*ACC_W +: ACC_W]
- o_sat  out  1  sticky flag: at least one lane saturated since reset

## Operation

- Storage: 2 banks × 16 rows × LANES*ACC_W register array. full[1:0] flags.
- Write side:
  - wr_bank (1b) and wr_row (4b) counters.
  - o_psum_ready = !full[wr_bank], computed from the registered flag.
  - Accepted beat targets bank[wr_bank][wr_row]. Per lane: first ? sext(psum) : sat(bank + sext(psum)).
  - The sum is computed at ACC_W+1 bits and clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Any clamp sets o_sat.
  - wr_row increments on every accepted beat and wraps 15→0.
  - An accepted beat with wr_row==15 and i_psum_last sets full[wr_bank] and toggles wr_bank.
  - first and last are sampled per beat. Upstream holds them constant across a 16-row chunk. first && last is legal: a single-chunk tile.
- Drain FSM, states IDLE, START, STREAM; rd_bank (1b), rd_row (4b):
  - IDLE: if full[rd_bank], go to START.
  - START: o_ppu_start=1, rd_row=0, go to STREAM.
  - STREAM: o_acc_data = bank[rd_bank][rd_row], rd_row++.
  - At rd_row==15: clear full[rd_bank] and toggle rd_bank. Go to START if full[other bank], else IDLE.
  - o_acc_data is 0 outside STREAM.
- Simultaneous events:
  - Set-full and clear-full on different banks in the same cycle both take effect.
  - A write to the bank being cleared this cycle is not possible: ready is still 0. This costs a one-cycle bubble, which is accepted.
- Both banks full: ready stays low until the drain of rd_bank completes.

## Timing

- Reset values:
  - o_psum_ready=1, o_ppu_start=0, o_acc_data=0, o_sat=0.
  - full=0, wr_bank=rd_bank=0, wr_row=rd_row=0, FSM=IDLE.
- Bank write is a single-cycle read-modify-write. full is registered.
- Last beat (row 15, last) accepted at cycle t:
  - full set, visible at t+1.
  - FSM is in START at t+2 (o_ppu_start high).
  - Row k presented at t+3+k; row 15 at t+18.
- Back-to-back tiles: o_ppu_start pulses are spaced exactly 17 cycles apart. This matches the PPU's 16-cycle busy window plus its one idle cycle.
- o_ppu_start is never asserted during STREAM.
- Reset mid-operation discards all data. No o_ppu_start until a complete tile is written again.

## Test plan

- Single-chunk tile: 16 beats, first=last=1, row r lane g = r*16+g → o_ppu_start at t+2; row r lane g = r*16+g at t+3+r; o_sat=0.
- Three-chunk accumulate: each chunk all lanes = 1000, second chunk = -300 → every streamed lane = 1700; exactly one o_ppu_start.
- Saturation: first chunk lanes = 2^19-1, then 20 more chunks of 2^19-1 → lanes clamp to 8388607 (2^23-1); o_sat=1 and stays 1. Same with negative values → -8388608.
- Ping-pong backpressure: stream 3 single-chunk tiles with valid held high → ready drops after tile 2 until tile 1's row 15 drains; start pulses exactly 17 cycles apart; tile order and data preserved.
- Row wrap without last: chunk of 16 beats with last=0, then 16 beats with last=1 → only one start; wr_bank toggles only after the second chunk.
- Reset asserted during STREAM row 7 → o_acc_data=0, o_ppu_start=0, ready=1 immediately; a new single-chunk tile afterwards drains from bank 0 with correct data.
